// File: rtl/uart_result_tx.sv
// Turns a signed result (or an error flag) into a decimal ASCII line and feeds it
// one byte at a time to a UART byte transmitter, pacing itself off tx_busy.
module uart_result_tx #(
  parameter int WIDTH = 16,
  parameter bit CRLF  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic             err,
  input  logic             start,
  output logic             ready,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  input  logic             tx_busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // Handshakes: a request is taken on any clock edge where start && ready.
  // A byte goes to the transmitter on an edge where SEND sees tx_busy=0; tx_en
  // is then high for exactly one cycle and tx_data holds until the next byte.

  localparam int NDIG = 5;
  localparam int BW   = 4 * NDIG;
  localparam int CW   = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    LOAD    = 3'd2,
    SEND    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    FIN     = 3'd6
  } state_t;

  state_t           state, state_n;
  logic             err_q;
  logic             neg_q;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt;
  logic [7:0]       byte_buf [8];
  logic [7:0]       fill [8];
  logic [3:0]       len;
  logic [3:0]       fill_len;
  logic [2:0]       idx;
  logic             last;
  logic             lead;
  logic [3:0]       digit;

  assign ready     = (state == IDLE);
  assign done      = (state == FIN);
  assign dbg_state = state;
  assign last      = ({1'b0, idx} == (len - 4'd1));

  // Double-dabble add-3 step, applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NDIG; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  // Line image built from the finished BCD value; leading zeros suppressed.
  always_comb begin
    fill     = '{default: 8'h00};
    fill_len = 4'd0;
    lead     = 1'b1;
    digit    = 4'd0;
    if (err_q) begin
      fill[0]  = 8'h45;
      fill[1]  = 8'h52;
      fill[2]  = 8'h52;
      fill_len = 4'd3;
    end else begin
      if (neg_q) begin
        fill[0]  = 8'h2D;
        fill_len = 4'd1;
      end
      for (int d = NDIG - 1; d >= 0; d--) begin
        digit = bcd[d*4 +: 4];
        if (digit != 4'd0 || d == 0) lead = 1'b0;
        if (!lead) begin
          fill[fill_len[2:0]] = {4'h3, digit};
          fill_len            = fill_len + 4'd1;
        end
      end
    end
    if (CRLF) begin
      fill[fill_len[2:0]] = 8'h0D;
      fill_len            = fill_len + 4'd1;
      fill[fill_len[2:0]] = 8'h0A;
      fill_len            = fill_len + 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = err ? LOAD : CONV;
      CONV:    if (cnt == CW'(WIDTH - 1)) state_n = LOAD;
      LOAD:    state_n = SEND;
      SEND:    if (!tx_busy) state_n = WAIT_HI;
      WAIT_HI: if (tx_busy) state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_n = last ? FIN : SEND;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      byte_buf <= '{default: 8'h00};
      len      <= 4'd0;
      idx      <= 3'd0;
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
    end else begin
      state <= state_n;
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_q <= err;
            neg_q <= result[WIDTH-1];
            mag   <= result[WIDTH-1] ? -result : result;
            bcd   <= '0;
            cnt   <= '0;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        LOAD: begin
          byte_buf <= fill;
          len      <= fill_len;
          idx      <= 3'd0;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= byte_buf[idx];
          end
        end
        WAIT_LO: begin
          if (!tx_busy) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: transmitter busy model, byte monitor and
// per-case expected byte queues with hand-computed ASCII lines.
module tb_uart_result_tx;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;

  logic        clk;
  logic        rst_n;
  logic [15:0] result;
  logic        err;
  logic        start;
  logic        ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        done;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         en_cyc_q[$];
  int         en_cnt   = 0;
  int         done_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_en  = 1'b0;

  logic force_busy = 1'b0;
  int   busy_cnt   = 0;

  uart_result_tx #(.WIDTH(16), .CRLF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .err       (err),
    .start     (start),
    .ready     (ready),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_busy   (tx_busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Transmitter model: latches on busy=0 & tx_en=1, busy high for 20 cycles.
  initial tx_busy = 1'b0;
  always @(posedge clk) begin
    if (force_busy) begin
      tx_busy <= 1'b1;
    end else if (tx_en && !tx_busy) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 19;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_en) begin
      got_q.push_back(tx_data);
      en_cyc_q.push_back(cyc);
      en_cnt = en_cnt + 1;
      if (prev_en) wide_cnt = wide_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    prev_en = tx_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_start(input logic [15:0] r, input logic e, output int c0);
    @(negedge clk);
    result = r;
    err    = e;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    c0     = cyc;
    result = 16'($urandom);
    err    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input bit jab, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (jab)
        start = (dbg_state >= ST_SEND && dbg_state <= ST_WAIT_LO) && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    if (ok) begin
      @(negedge clk);
      check("ready_after_done", ready, 1'b1);
    end
  endtask

  task automatic compare_bytes(input string tag, input int base);
    check({tag, "_nbytes"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        check($sformatf("%s_b%0d", tag, i), got_q[base + i], exp_q[i]);
    end
  endtask

  task automatic run_case(input string tag, input logic [15:0] r, input logic e, input int lat);
    int base, base_done, c0;
    bit ok;
    base      = got_q.size();
    base_done = done_cnt;
    pulse_start(r, e, c0);
    wait_done(1'b0, ok);
    check({tag, "_done_seen"}, ok, 1'b1);
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    if (got_q.size() > base) check({tag, "_first_lat"}, en_cyc_q[base] - c0, lat);
    compare_bytes(tag, base);
  endtask

  initial begin
    int base, base_en, base_done, c0;
    bit ok;
    rst_n  = 1'b0;
    start  = 1'b0;
    err    = 1'b0;
    result = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    run_case("v1234", 16'd1234, 1'b0, 18);
    exp_q = '{8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0D, 8'h0A};
    run_case("vmin", 16'h8000, 1'b0, 18);
    exp_q = '{8'h2D, 8'h31, 8'h0D, 8'h0A};
    run_case("vneg1", 16'hFFFF, 1'b0, 18);
    exp_q = '{8'h30, 8'h0D, 8'h0A};
    run_case("vzero", 16'h0000, 1'b0, 18);
    exp_q = '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    run_case("v10000", 16'd10000, 1'b0, 18);
    exp_q = '{8'h33, 8'h32, 8'h37, 8'h36, 8'h37, 8'h0D, 8'h0A};
    run_case("vmax", 16'h7FFF, 1'b0, 18);
    exp_q = '{8'h39, 8'h0D, 8'h0A};
    run_case("v9", 16'd9, 1'b0, 18);
    exp_q = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    run_case("verr", 16'h1234, 1'b1, 2);

    // busy held high at SEND entry, extra starts while sending
    exp_q     = '{8'h34, 8'h32, 8'h0D, 8'h0A};
    base      = got_q.size();
    base_en   = en_cnt;
    base_done = done_cnt;
    force_busy = 1'b1;
    pulse_start(16'd42, 1'b0, c0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state == ST_SEND) begin
        ok = 1'b1;
        break;
      end
    end
    check("hold_reach_send", ok, 1'b1);
    repeat (50) @(negedge clk);
    check("hold_no_en", en_cnt - base_en, 0);
    check("hold_state", dbg_state, ST_SEND);
    force_busy = 1'b0;
    wait_done(1'b1, ok);
    check("hold_done_seen", ok, 1'b1);
    repeat (40) @(negedge clk);
    check("hold_no_extra_en", en_cnt - base_en, 4);
    check("hold_done_pulses", done_cnt - base_done, 1);
    check("hold_idle", ready, 1'b1);
    compare_bytes("hold", base);
    check("en_width", wide_cnt, 0);

    // reset during the third byte's WAIT_LO
    base_en = en_cnt;
    pulse_start(16'd1234, 1'b0, c0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (en_cnt - base_en == 3 && dbg_state == ST_WAIT_LO) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst3_reach", ok, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst3_tx_en", tx_en, 1'b0);
    check("rst3_tx_data", tx_data, 8'h00);
    check("rst3_ready", ready, 1'b1);
    check("rst3_done", done, 1'b0);
    rst_n     = 1'b1;
    base_done = done_cnt;
    repeat (60) @(negedge clk);
    check("rst3_no_more_en", en_cnt - base_en, 3);
    check("rst3_no_done", done_cnt - base_done, 0);

    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    run_case("after_rst", 16'd1234, 1'b0, 18);
    check("en_width_final", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

Formats a signed calculator result (or an error indication) into a decimal ASCII line and hands it byte-by-byte to the UART transmitter. It sits directly upstream of the UART byte transmitter. It drives that transmitter's 8-bit data input and one-cycle data-enable, and paces itself off the transmitter's busy flag. Conversion is sequential (double-dabble), so no divider is required.

## Interface
- `WIDTH`, 16: result width, two's complement. Magnitude fits in WIDTH unsigned bits. 5 BCD digits cover WIDTH=16.
- `CRLF`, 1: 1 = append 8'h0D, 8'h0A after the text; 0 = no line terminator.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  synchronous, active-low reset.
- `result`  in  WIDTH  signed value to print; sampled when `start` is accepted.
- `err`  in  1  sampled with `result`; 1 = print "ERR" instead of the number.
- `start`  in  1  request pulse; accepted only when `ready`=1.
- `ready`  out  1  high in IDLE only.
- `tx_data`  out  8  byte to the transmitter; held stable from the cycle `tx_en` is high until the next byte is loaded.
- `tx_en`  out  1  one-cycle data-enable to the transmitter.
- `tx_busy`  in  1  transmitter busy flag.
- `done`  out  1  one-cycle pulse after the last byte's `tx_busy` falls.

## Operation
- States: IDLE, CONV, LOAD, SEND, WAIT_HI, WAIT_LO, FIN.
- IDLE: `ready`=1. When `start`=1:
  - capture `err` and `result`;
  - compute magnitude, where negative values use two's-complement negate, so -32768 gives 16'h8000;
  - store the sign bit;
  - clear the 20-bit BCD register and the iteration counter;
  - go to CONV.
- CONV: one double-dabble iteration per cycle.
  - Each BCD nibble ≥5 gets +3.
  - Then shift {bcd, mag} left by 1.
  - After exactly WIDTH iterations, go to LOAD.
  - If `err`=1, skip CONV and go straight to LOAD.
- LOAD: fill an 8-entry byte buffer and a length count (1..8).
  - err=1: 'E','R','R' (8'h45, 8'h52, 8'h52).
  - err=0: optional '-' (8'h2D) when the sign is set, then the digits from the most significant nonzero digit down as 8'h30+digit. Value 0 produces the single byte '0'.
  - CRLF=1: append 8'h0D, 8'h0A.
  - Reset the byte index to 0 and go to SEND.
- SEND: when `tx_busy`=0, on the clock edge:
  - `tx_data` = buf[index];
  - `tx_en` = 1;
  - go to WAIT_HI.
  - If `tx_busy`=1, stay in SEND with `tx_en`=0.
- WAIT_HI: `tx_en` returns to 0 on the edge that enters WAIT_HI +1, so it is high for exactly one cycle. Wait for `tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_busy`=0.
  - Then index+1. If index = len-1, go to FIN; else go to SEND.
  - If the transmitter is reset mid-byte, `tx_busy` drops early. The byte is treated as sent; no retry.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `result`/`err` changes after acceptance have no effect.

## Timing
- Reset values:
  - state = IDLE, `ready`=1;
  - `tx_en`=0, `tx_data`=8'h00, `done`=0;
  - BCD/buffer/counters cleared.
- Reset wins over every other event, including mid-CONV and mid-SEND. No `tx_en` is issued after `rst_n` goes low.
- Edge E0 samples `start`. Then:
  - CONV occupies E1..E16 (WIDTH=16);
  - LOAD is at E17;
  - the earliest `tx_en`=1 is on E18, when `tx_busy`=0 in that cycle.
  - The err path skips CONV: earliest `tx_en` on E2.
- Byte spacing is governed by `tx_busy`. There is a minimum 3 cycles between `tx_en` pulses: SEND→WAIT_HI→WAIT_LO→SEND.
- `done` is asserted one cycle after the last WAIT_LO exit. `ready` rises the following cycle.
- The transmitter latches on busy=0 & data_en=1 and raises busy on the next edge. WAIT_HI therefore always sees busy within 1 cycle, so there is no double-issue.

## Test plan
- result=16'd1234, err=0, CRLF=1 → bytes 31 32 33 34 0D 0A, six `tx_en` pulses, one `done`; bench busy model: rises 1 cycle after `tx_en`, high 20 cycles.
- result=16'h8000 (-32768) → 2D 33 32 37 36 38 0D 0A; result=-1 → 2D 31 0D 0A.
- result=0 → 30 0D 0A; result=16'd10000 → 31 30 30 30 30 0D 0A (interior zeros kept).
- err=1, result=any → 45 52 52 0D 0A; first `tx_en` exactly 2 edges after `start`.
- Second `start` pulses while sending, plus `tx_busy` held high at SEND entry for 50 cycles → second request ignored, `tx_en` withheld until busy low, each `tx_en` exactly one cycle wide.
- `rst_n`=0 for 1 cycle during the 3rd byte's WAIT_LO → next edge: `tx_en`=0, `tx_data`=00, `ready`=1, `done`=0; no further `tx_en`; a fresh `start` works normally.
